cache_latency_shim: RTL and testbench

Testbench stage between the core's memory port and the zero-latency `cache` byte-memory model. It forwards core requests to the cache but imposes realistic timing: line-tag hit detection, multi-cycle miss stalls, range and alignment aborts, and cancellation on `i_recover`. It lets pipeline stall, abort and recover paths be exercised without changing the memory model.

---
 rtl/cache_latency_shim_if.sv | 30 +++
 rtl/cache_latency_shim.sv | 142 ++++++++++++++
 tb/tb_cache_latency_shim.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_latency_shim_if.sv
// Core-side memory port and cache-side strobe bundle for cache_latency_shim.
// The shim takes the slave view; the core/cache model side takes the master view.
interface cache_latency_shim_if;
  logic [31:0] i_address;
  logic [31:0] i_data;
  logic        i_rd_en;
  logic        i_wr_en;
  logic        i_recover;
  logic [31:0] o_data;
  logic        o_hit;
  logic        o_miss;
  logic        o_abort;
  logic [31:0] o_cache_address;
  logic [31:0] o_cache_data;
  logic        o_cache_rd_en;
  logic        o_cache_wr_en;
  logic [31:0] i_cache_data;

  modport slave (
    input  i_address, i_data, i_rd_en, i_wr_en, i_recover, i_cache_data,
    output o_data, o_hit, o_miss, o_abort,
    output o_cache_address, o_cache_data, o_cache_rd_en, o_cache_wr_en
  );

  modport master (
    output i_address, i_data, i_rd_en, i_wr_en, i_recover, i_cache_data,
    input  o_data, o_hit, o_miss, o_abort,
    input  o_cache_address, o_cache_data, o_cache_rd_en, o_cache_wr_en
  );
endinterface

// File: rtl/cache_latency_shim.sv
// Timing shim between core memory port and a zero-latency cache model: single-line tag
// hit detection, multi-cycle miss stall, range/alignment abort, recover cancel.
// Optional random miss latency: define ZAP_TB_RAND_LATENCY_EN.
module cache_latency_shim #(
  parameter int MEM_BYTES    = 1024,
  parameter int LINE_BYTES   = 16,
  parameter int MISS_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  cache_latency_shim_if.slave   bus
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = 32 - OFF_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [4:0] BASE_M1 = 5'(MISS_LATENCY - 1);

  logic [0:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             tag_valid_q, tag_valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             req;
  logic             is_wr;
  logic             fault;
  logic             tag_hit;
  logic [TAG_W-1:0] req_tag;
  logic [4:0]       lat_m1;

  logic             hit, miss, abort, rd_stb, wr_stb;
  logic [31:0]      rdata;

`ifdef ZAP_TB_RAND_LATENCY_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    lat_m1  = BASE_M1 + {3'b000, lfsr_q[1:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    lat_m1 = BASE_M1;
  end
`endif

  always_comb begin
    req     = bus.i_rd_en | bus.i_wr_en;
    is_wr   = bus.i_wr_en;
    fault   = (bus.i_address >= 32'(MEM_BYTES)) | (bus.i_address[1:0] != 2'b00);
    req_tag = bus.i_address[31:OFF_W];
    tag_hit = tag_valid_q && (tag_q == req_tag);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    hit         = 1'b0;
    miss        = 1'b0;
    abort       = 1'b0;
    rd_stb      = 1'b0;
    wr_stb      = 1'b0;
    rdata       = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (!req) begin
          hit = 1'b1;
        end else if (fault) begin
          hit   = 1'b1;
          abort = 1'b1;
        end else if (tag_hit) begin
          hit    = 1'b1;
          wr_stb = is_wr;
          rd_stb = !is_wr;
          rdata  = is_wr ? 32'h0 : bus.i_cache_data;
        end else begin
          miss    = 1'b1;
          state_d = S_WAIT;
          cnt_d   = lat_m1;
        end
      end
      default: begin
        // Reset is folded into the cancel path so a completing access never strobes under reset.
        if (bus.i_recover || !req || i_reset) begin
          hit     = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != 5'd0) begin
          miss  = 1'b1;
          cnt_d = cnt_q - 5'd1;
        end else begin
          hit         = 1'b1;
          wr_stb      = is_wr;
          rd_stb      = !is_wr;
          rdata       = is_wr ? 32'h0 : bus.i_cache_data;
          tag_d       = req_tag;
          tag_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  // Tag payload needs no reset; tag_valid_q qualifies it.
  always_ff @(posedge i_clk) begin
    tag_q <= tag_d;
  end

  assign bus.o_data          = rdata;
  assign bus.o_hit           = hit;
  assign bus.o_miss          = miss;
  assign bus.o_abort         = abort;
  assign bus.o_cache_address = bus.i_address;
  assign bus.o_cache_data    = bus.i_data;
  assign bus.o_cache_rd_en   = rd_stb;
  assign bus.o_cache_wr_en   = wr_stb;

endmodule

// File: tb/tb_cache_latency_shim.sv
// Directed bench for cache_latency_shim with a little-endian byte-memory cache model.
module tb_cache_latency_shim;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_latency_shim_if bus();

  cache_latency_shim #(
    .MEM_BYTES(1024), .LINE_BYTES(16), .MISS_LATENCY(3)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'h0;
  logic [31:0] pl_data = 32'h0;
  logic [9:0]  ra;

  assign ra = bus.o_cache_address[9:0];
  assign bus.i_cache_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]         <= pl_data[7:0];
      mem[pl_addr + 10'd1] <= pl_data[15:8];
      mem[pl_addr + 10'd2] <= pl_data[23:16];
      mem[pl_addr + 10'd3] <= pl_data[31:24];
    end else if (bus.o_cache_wr_en) begin
      mem[ra]         <= bus.o_cache_data[7:0];
      mem[ra + 10'd1] <= bus.o_cache_data[15:8];
      mem[ra + 10'd2] <= bus.o_cache_data[23:16];
      mem[ra + 10'd3] <= bus.o_cache_data[31:24];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rec,
                       input logic [31:0] a, input logic [31:0] d);
    bus.i_rd_en     = rd;
    bus.i_wr_en     = wr;
    bus.i_recover   = rec;
    bus.i_address   = a;
    bus.i_data      = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits for the falling edge, then compares every status/strobe output.
  task automatic outs(input string tag, input logic h, input logic m, input logic ab,
                      input logic r, input logic w, input logic [31:0] dat);
    @(negedge clk);
    chk({tag, ".hit"},   {31'b0, bus.o_hit},         {31'b0, h});
    chk({tag, ".miss"},  {31'b0, bus.o_miss},        {31'b0, m});
    chk({tag, ".abort"}, {31'b0, bus.o_abort},       {31'b0, ab});
    chk({tag, ".rd"},    {31'b0, bus.o_cache_rd_en}, {31'b0, r});
    chk({tag, ".wr"},    {31'b0, bus.o_cache_wr_en}, {31'b0, w});
    chk({tag, ".data"},  bus.o_data,                 dat);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    preload(10'h010, 32'h11223344);
    preload(10'h01C, 32'hCAFEF00D);
    preload(10'h040, 32'h55667788);
    preload(10'h080, 32'h00000000);
    do_reset();

    outs("rst_idle", 1, 0, 0, 0, 0, 32'h0);
    tick();

    // Cold read miss of 0x10, three stall cycles then completion
    drive(1, 0, 0, 32'h10, 32'h0);
    outs("rd10_c0", 0, 1, 0, 0, 0, 32'h0);
    chk("rd10_addr", bus.o_cache_address, 32'h10);
    tick();
    outs("rd10_c1", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("rd10_c2", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("rd10_c3", 1, 0, 0, 1, 0, 32'h11223344);
    tick();

    // Same line, back-to-back: zero-latency hit
    drive(1, 0, 0, 32'h1C, 32'h0);
    outs("rd1c_hit", 1, 0, 0, 1, 0, 32'hCAFEF00D);
    tick();

    // Different line misses; drop the request mid-stall to cancel
    drive(1, 0, 0, 32'h20, 32'h0);
    outs("rd20_miss", 0, 1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h20, 32'h0);
    outs("rd20_drop", 1, 0, 0, 0, 0, 32'h0);
    tick();

    // Aborts after a fresh reset; tag must stay invalid
    do_reset();
    drive(1, 0, 0, 32'h400, 32'h0);
    outs("ab400", 1, 0, 1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h13, 32'h0);
    outs("ab13", 1, 0, 1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h10, 32'h0);
    outs("rd10_after_ab", 0, 1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    tick();

    // Recover cancels in the same cycle; re-read takes the full miss
    drive(1, 0, 0, 32'h40, 32'h0);
    outs("rd40_c0", 0, 1, 0, 0, 0, 32'h0);
    tick();
    drive(1, 0, 1, 32'h40, 32'h0);
    outs("rd40_rec", 1, 0, 0, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h40, 32'h0);
    outs("rd40_r0", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("rd40_r1", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("rd40_r2", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("rd40_r3", 1, 0, 0, 1, 0, 32'h55667788);
    tick();

    // Write miss with allocate, then read hits with the written word
    drive(0, 1, 0, 32'h80, 32'hDEADBEEF);
    outs("wr80_c0", 0, 1, 0, 0, 0, 32'h0);
    chk("wr80_cdata", bus.o_cache_data, 32'hDEADBEEF);
    tick();
    outs("wr80_c1", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("wr80_c2", 0, 1, 0, 0, 0, 32'h0);
    tick();
    outs("wr80_c3", 1, 0, 0, 0, 1, 32'h0);
    tick();
    drive(1, 0, 0, 32'h80, 32'h0);
    outs("rd80_hit", 1, 0, 0, 1, 0, 32'hDEADBEEF);
    tick();

    // Both enables: treated as a write hit on the allocated line
    drive(1, 1, 0, 32'h84, 32'h0BADF00D);
    outs("rw84_hit", 1, 0, 0, 0, 1, 32'h0);
    tick();
    drive(1, 0, 0, 32'h84, 32'h0);
    outs("rd84_hit", 1, 0, 0, 1, 0, 32'h0BADF00D);
    tick();

    // Reset during a stall: no strobe, and the old line is forgotten
    drive(1, 0, 0, 32'h100, 32'h0);
    outs("rd100_c0", 0, 1, 0, 0, 0, 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_rd", {31'b0, bus.o_cache_rd_en}, 32'h0);
    chk("rstwait_wr", {31'b0, bus.o_cache_wr_en}, 32'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);
    outs("post_rst_idle", 1, 0, 0, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h80, 32'h0);
    outs("rd80_after_rst", 0, 1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
